ride_dispatcher: RTL and testbench
==================================

Name: ride_dispatcher

Overview:
- Consumer end of the waiting-queue counter: the ride side that removes one batch of riders from the queue, then loads, runs and unloads the ride.
- Requests a batch from the queue block over a req/ack handshake; the queue subtracts CAPACITY on acknowledge.
- Sequences LOAD/RUN/UNLOAD phases from the slowed-clock tick; drives a state digit and a completed-ride digit on 7-segment displays.

Parameters:
- CAPACITY, 8, riders taken per dispatch (queue decrement on ack)
- CNT_W, 5, width of queue_count (queue holds 0..20)
- LOAD_TICKS, 2, tick pulses spent in LOAD
- RIDE_TICKS, 5, tick pulses spent in RUN
- UNLOAD_TICKS, 2, tick pulses spent in UNLOAD

Ports:
- CLOCK_50  in  1  system clock
- RESET  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle enable pulse from the slow-clock divider
- start_btn  in  1  operator dispatch switch, level; rising edge used
- queue_count  in  CNT_W  current waiting count from the queue block
- take_ack  in  1  queue has subtracted CAPACITY this cycle
- take_req  out  1  request one batch; held until ack
- reject  out  1  one-cycle pulse: start pressed with queue_count < CAPACITY
- riders  out  4  riders on board (0 or CAPACITY)
- busy  out  1  state != IDLE
- HEX4  out  [0:6]  state digit (0=IDLE,1=REQ,2=LOAD,3=RUN,4=UNLOAD)
- HEX5  out  [0:6]  completed-ride count digit 0..9

Behaviour:
- Reset (async, RESET=1): state=IDLE, take_req=0, reject=0, riders=0, ride_count=0, timer=0, start edge register=0. HEX4 and HEX5 show "0" (7'b000_0001).
- Outputs are registered; responses appear one CLOCK_50 cycle after the causing input.
- Start edge: start_prev registered every cycle; edge = start_btn & ~start_prev. Edges outside IDLE are discarded, not queued.
- IDLE:
  - on edge with queue_count >= CAPACITY -> REQ.
  - on edge with queue_count < CAPACITY -> stay IDLE; reject=1 for exactly one cycle.
- REQ: take_req=1.
  - take_ack=1 -> LOAD; riders<=CAPACITY; take_req=0 next cycle.
  - take_ack=0 with queue_count < CAPACITY -> IDLE; take_req=0.
  - ack and count drop in the same cycle: ack wins.
- LOAD: timer counts tick pulses; on the tick where timer==LOAD_TICKS-1 -> RUN.
- RUN: on entry, ride_count increments, wrapping 9->0. On tick with timer==RIDE_TICKS-1 -> UNLOAD.
- UNLOAD: on tick with timer==UNLOAD_TICKS-1 -> IDLE; riders<=0.
- Timer clears to 0 on every state change; advances only on cycles with tick=1.
- take_ack outside REQ is ignored.
- Illegal state encodings recover to IDLE next cycle; HEX shows 7'b111_1111 while illegal.
- 7-segment: active-low, bit 0 = segment a; same digit codes as the queue displays (0=000_0001, 1=100_1111, 2=001_0010, 3=000_0110, 4=100_1100, 5=010_0100, 6=010_0000, 7=000_1111, 8=000_0000, 9=000_1100).
- RESET mid-operation: immediate return to IDLE; take_req drops asynchronously; ride_count is lost.

Optional Feature:
- Macro RIDE_ESTOP_EN.
- Defined: adds input estop (1 bit).
  - While estop=1 in LOAD/RUN/UNLOAD: timer frozen and ticks ignored; HEX4 shows 8 (7'b000_0000).
  - In REQ: take_req forced 0 and ack ignored.
  - Start edges in IDLE are ignored, with no reject pulse.
  - Release resumes from the frozen timer value.
- Undefined: no estop port; behaviour as above.

Test Plan:
- Reset check: RESET pulse mid-RUN -> state IDLE, take_req=0, riders=0, HEX4=HEX5=7'b000_0001.
- Full cycle: queue_count=12, start edge -> take_req=1 next cycle; ack after 3 cycles -> LOAD, riders=8. Ticks 2/5/2 -> RUN then UNLOAD then IDLE; HEX5 reaches 1, riders=0.
- Reject: queue_count=4, start edge -> reject high for exactly 1 cycle; take_req stays 0; state IDLE.
- Request abort: in REQ, queue_count falls 8->0 with no ack -> IDLE, take_req=0. Same drop with simultaneous ack -> LOAD.
- Wrap and edge filtering: 10 full rides -> HEX5 returns to 0 (7'b000_0001). start_btn held high across rides gives no extra dispatch; start toggled during RUN is ignored.
- (RIDE_ESTOP_EN) estop=1 for 4 ticks in RUN at timer=2 -> HEX4=8, no transition. Release -> UNLOAD after exactly 3 further ticks.

Source files
------------

// File: rtl/ride_dispatcher.sv
// rtl/ride_dispatcher.sv - ride-side consumer: batch request, LOAD/RUN/UNLOAD sequencing, 7-seg status
// Optional emergency stop input enabled by defining RIDE_ESTOP_EN.
module ride_dispatcher #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 5,
  parameter int LOAD_TICKS   = 2,
  parameter int RIDE_TICKS   = 5,
  parameter int UNLOAD_TICKS = 2
) (
  input  logic             CLOCK_50,
  input  logic             RESET,
  input  logic             tick,
  input  logic             start_btn,
  input  logic [CNT_W-1:0] queue_count,
  input  logic             take_ack,
`ifdef RIDE_ESTOP_EN
  input  logic             estop,
`endif
  output logic             take_req,
  output logic             reject,
  output logic [3:0]       riders,
  output logic             busy,
  output logic [0:6]       HEX4,
  output logic [0:6]       HEX5
);

  localparam int TMR_MAX = (RIDE_TICKS > LOAD_TICKS) ?
                           ((RIDE_TICKS > UNLOAD_TICKS) ? RIDE_TICKS : UNLOAD_TICKS) :
                           ((LOAD_TICKS > UNLOAD_TICKS) ? LOAD_TICKS : UNLOAD_TICKS);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    RUN    = 3'd3,
    UNLOAD = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [3:0]       riders_q, riders_d;
  logic [3:0]       count_q, count_d;
  logic             reject_q, reject_d;
  logic             start_prev_q;
  logic             start_edge;
  logic             estop_w;
  logic             legal;
  logic             ride_phase;

`ifdef RIDE_ESTOP_EN
  assign estop_w = estop;
`else
  assign estop_w = 1'b0;
`endif

  function automatic logic [0:6] seg7(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'd0:    s = 7'b000_0001;
      4'd1:    s = 7'b100_1111;
      4'd2:    s = 7'b001_0010;
      4'd3:    s = 7'b000_0110;
      4'd4:    s = 7'b100_1100;
      4'd5:    s = 7'b010_0100;
      4'd6:    s = 7'b010_0000;
      4'd7:    s = 7'b000_1111;
      4'd8:    s = 7'b000_0000;
      4'd9:    s = 7'b000_1100;
      default: s = 7'b111_1111;
    endcase
    return s;
  endfunction

  assign start_edge = start_btn & ~start_prev_q;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    riders_d = riders_q;
    count_d  = count_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge && !estop_w) begin
          if (queue_count >= CNT_W'(CAPACITY)) state_d = REQ;
          else                                 reject_d = 1'b1;
        end
      end
      REQ: begin
        // A simultaneous ack beats the count dropping below a batch.
        if (take_ack && !estop_w) begin
          state_d  = LOAD;
          riders_d = 4'(CAPACITY);
        end else if (queue_count < CNT_W'(CAPACITY)) begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (tick && !estop_w) begin
          if (timer_q == TMR_W'(LOAD_TICKS - 1)) begin
            state_d = RUN;
            count_d = (count_q >= 4'd9) ? 4'd0 : count_q + 4'd1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      RUN: begin
        if (tick && !estop_w) begin
          if (timer_q == TMR_W'(RIDE_TICKS - 1)) state_d = UNLOAD;
          else                                   timer_d = timer_q + 1'b1;
        end
      end
      UNLOAD: begin
        if (tick && !estop_w) begin
          if (timer_q == TMR_W'(UNLOAD_TICKS - 1)) begin
            state_d  = IDLE;
            riders_d = 4'd0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        riders_d = 4'd0;
      end
    endcase
    if (state_d != state_q) timer_d = '0;
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      riders_q     <= 4'd0;
      count_q      <= 4'd0;
      reject_q     <= 1'b0;
      start_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      riders_q     <= riders_d;
      count_q      <= count_d;
      reject_q     <= reject_d;
      start_prev_q <= start_btn;
    end
  end

  always_comb begin
    legal      = (state_q == IDLE) || (state_q == REQ) || (state_q == LOAD) ||
                 (state_q == RUN)  || (state_q == UNLOAD);
    ride_phase = (state_q == LOAD) || (state_q == RUN) || (state_q == UNLOAD);
    if (!legal)                      HEX4 = 7'b111_1111;
    else if (ride_phase && estop_w)  HEX4 = 7'b000_0000;
    else                             HEX4 = seg7({1'b0, state_q});
    HEX5 = legal ? seg7(count_q) : 7'b111_1111;
  end

  assign take_req = (state_q == REQ) && !estop_w;
  assign reject   = reject_q;
  assign riders   = riders_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ride_dispatcher.sv
// tb/tb_ride_dispatcher.sv - scoreboard bench for ride_dispatcher
module tb_ride_dispatcher;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       start_btn;
  logic [4:0] queue_count;
  logic       take_ack;
`ifdef RIDE_ESTOP_EN
  logic       estop;
`endif
  logic       take_req;
  logic       reject;
  logic [3:0] riders;
  logic       busy;
  logic [0:6] HEX4;
  logic [0:6] HEX5;

  int errors = 0;
  int checks = 0;
  int exp_rides = 0;
  logic [0:6] sb_q[$];
  logic [0:6] exp_hex;

  ride_dispatcher dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .tick       (tick),
    .start_btn  (start_btn),
    .queue_count(queue_count),
    .take_ack   (take_ack),
`ifdef RIDE_ESTOP_EN
    .estop      (estop),
`endif
    .take_req   (take_req),
    .reject     (reject),
    .riders     (riders),
    .busy       (busy),
    .HEX4       (HEX4),
    .HEX5       (HEX5)
  );

  always #10 clk = ~clk;

  function automatic logic [0:6] seg(input int d);
    logic [0:6] s;
    case (d)
      0: s = 7'b000_0001;
      1: s = 7'b100_1111;
      2: s = 7'b001_0010;
      3: s = 7'b000_0110;
      4: s = 7'b100_1100;
      5: s = 7'b010_0100;
      6: s = 7'b010_0000;
      7: s = 7'b000_1111;
      8: s = 7'b000_0000;
      9: s = 7'b000_1100;
      default: s = 7'b111_1111;
    endcase
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (HEX4 !== seg(0)) begin errors++; $display("FAIL reset_hex4: got %b expected %b", HEX4, seg(0)); end
    checks++; if (HEX5 !== seg(0)) begin errors++; $display("FAIL reset_hex5: got %b expected %b", HEX5, seg(0)); end
    checks++; if ({take_req, reject, busy, riders} !== 7'b0) begin errors++; $display("FAIL reset_outs: got %b expected 0000000", {take_req, reject, busy, riders}); end
    rst = 1'b0;
    step();
  endtask

  task automatic dispatch(input int qc);
    queue_count = 5'(qc);
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    checks++; if (take_req !== 1'b1) begin errors++; $display("FAIL dispatch_req: got %b expected 1", take_req); end
    checks++; if (HEX4 !== seg(1)) begin errors++; $display("FAIL dispatch_hex4: got %b expected %b", HEX4, seg(1)); end
  endtask

  task automatic push_ride();
    exp_rides = (exp_rides + 1) % 10;
    sb_q.push_back(seg(exp_rides));
  endtask

  task automatic pop_ride_check();
    checks++;
    if (sb_q.size() == 0) begin
      errors++; $display("FAIL ride_sb: got RUN entry expected none pending");
    end else begin
      exp_hex = sb_q.pop_front();
      if (HEX5 !== exp_hex) begin errors++; $display("FAIL ride_hex5: got %b expected %b", HEX5, exp_hex); end
    end
  endtask

  task automatic ack_load(input int delay);
    for (int i = 0; i < delay; i++) begin
      step();
      checks++; if (take_req !== 1'b1) begin errors++; $display("FAIL ack_wait_req: got %b expected 1", take_req); end
    end
    take_ack = 1'b1;
    step();
    take_ack = 1'b0;
    checks++; if (HEX4 !== seg(2)) begin errors++; $display("FAIL load_hex4: got %b expected %b", HEX4, seg(2)); end
    checks++; if ({take_req, riders} !== 5'b0_1000) begin errors++; $display("FAIL load_req_riders: got %b expected 01000", {take_req, riders}); end
    push_ride();
  endtask

  task automatic enter_run();
    tick_pulse();
    checks++; if (HEX4 !== seg(2)) begin errors++; $display("FAIL load_hold: got %b expected %b", HEX4, seg(2)); end
    tick_pulse();
    checks++; if (HEX4 !== seg(3)) begin errors++; $display("FAIL run_enter: got %b expected %b", HEX4, seg(3)); end
    pop_ride_check();
  endtask

  task automatic finish_ride(input bit toggle_in_run);
    enter_run();
    for (int i = 0; i < 4; i++) begin
      tick_pulse();
      if (toggle_in_run && i == 1) begin
        start_btn = 1'b0;
        step();
        start_btn = 1'b1;
        step();
      end
    end
    checks++; if (HEX4 !== seg(3)) begin errors++; $display("FAIL run_hold: got %b expected %b", HEX4, seg(3)); end
    tick_pulse();
    checks++; if (HEX4 !== seg(4)) begin errors++; $display("FAIL unload_enter: got %b expected %b", HEX4, seg(4)); end
    tick_pulse();
    checks++; if (HEX4 !== seg(4)) begin errors++; $display("FAIL unload_hold: got %b expected %b", HEX4, seg(4)); end
    tick_pulse();
    checks++; if ({busy, riders} !== 5'b0) begin errors++; $display("FAIL ride_end: got busy/riders %b expected 00000", {busy, riders}); end
    step(); step(); step();
    checks++; if ({busy, take_req} !== 2'b00) begin errors++; $display("FAIL no_redispatch: got %b expected 00", {busy, take_req}); end
  endtask

  task automatic test_full_cycle();
    dispatch(12);
    ack_load(3);
    finish_ride(1'b0);
    checks++; if (HEX5 !== seg(1)) begin errors++; $display("FAIL full_hex5: got %b expected %b", HEX5, seg(1)); end
  endtask

  task automatic test_reject();
    queue_count = 5'd4;
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    step();
    checks++; if ({reject, take_req, busy} !== 3'b100) begin errors++; $display("FAIL reject_pulse: got %b expected 100", {reject, take_req, busy}); end
    take_ack = 1'b1;
    step();
    take_ack = 1'b0;
    checks++; if ({reject, take_req, busy} !== 3'b000) begin errors++; $display("FAIL reject_end: got %b expected 000", {reject, take_req, busy}); end
    step();
    checks++; if ({riders, busy} !== 5'b0) begin errors++; $display("FAIL stray_ack: got %b expected 00000", {riders, busy}); end
  endtask

  task automatic test_abort();
    dispatch(8);
    queue_count = 5'd0;
    step();
    checks++; if ({take_req, busy} !== 2'b00) begin errors++; $display("FAIL abort: got %b expected 00", {take_req, busy}); end
    checks++; if (HEX4 !== seg(0)) begin errors++; $display("FAIL abort_hex4: got %b expected %b", HEX4, seg(0)); end
    dispatch(8);
    queue_count = 5'd0;
    ack_load(0);
    finish_ride(1'b0);
  endtask

  task automatic test_reset_mid_run();
    dispatch(12);
    ack_load(0);
    enter_run();
    tick_pulse();
    tick_pulse();
    rst = 1'b1;
    #1;
    checks++; if ({take_req, busy, riders} !== 6'b0) begin errors++; $display("FAIL midrun_reset_outs: got %b expected 000000", {take_req, busy, riders}); end
    checks++; if (HEX4 !== seg(0) || HEX5 !== seg(0)) begin errors++; $display("FAIL midrun_reset_hex: got %b %b expected %b %b", HEX4, HEX5, seg(0), seg(0)); end
    exp_rides = 0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_wrap_and_filter();
    for (int r = 0; r < 10; r++) begin
      dispatch(20);
      ack_load(1);
      finish_ride(r == 3);
    end
    checks++; if (HEX5 !== 7'b000_0001) begin errors++; $display("FAIL wrap_hex5: got %b expected 0000001", HEX5); end
  endtask

`ifdef RIDE_ESTOP_EN
  task automatic test_estop();
    dispatch(12);
    ack_load(0);
    enter_run();
    tick_pulse();
    tick_pulse();
    estop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_pulse();
      checks++; if (HEX4 !== 7'b000_0000) begin errors++; $display("FAIL estop_hex4: got %b expected 0000000", HEX4); end
    end
    estop = 1'b0;
    step();
    checks++; if (HEX4 !== seg(3)) begin errors++; $display("FAIL estop_release: got %b expected %b", HEX4, seg(3)); end
    tick_pulse();
    tick_pulse();
    checks++; if (HEX4 !== seg(3)) begin errors++; $display("FAIL estop_resume_hold: got %b expected %b", HEX4, seg(3)); end
    tick_pulse();
    checks++; if (HEX4 !== seg(4)) begin errors++; $display("FAIL estop_resume_unload: got %b expected %b", HEX4, seg(4)); end
    tick_pulse();
    tick_pulse();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL estop_idle: got %b expected 0", busy); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    start_btn = 1'b0;
    queue_count = 5'd0;
    take_ack = 1'b0;
`ifdef RIDE_ESTOP_EN
    estop = 1'b0;
`endif
    test_reset();
    test_full_cycle();
    test_reject();
    test_abort();
    test_reset_mid_run();
    test_wrap_and_filter();
`ifdef RIDE_ESTOP_EN
    test_estop();
`endif
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
